// File: rtl/vreg_pkg.sv
// Shared types for the vector register bank: command encoding and load FSM state.
package vreg_pkg;

  typedef enum logic [1:0] {
    SINGLE = 2'b00,
    GROUP  = 2'b01,
    FULL   = 2'b10,
    CLEAR  = 2'b11
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_e;

  function automatic int beat_ctr_width(input int nregs, input int lanes);
    int nb;
    nb = nregs / lanes;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/vreg_beat_ctr.sv
// Beat counter for multi-beat FULL loads: wraps to 0 after the terminal beat.
// Synchronous clear has priority over enable.
module vreg_beat_ctr #(
  parameter int NBEATS = 4,
  parameter int CW     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clr,
  output logic [CW-1:0] cnt,
  output logic          tc
);

  assign tc = (cnt == CW'(NBEATS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/vreg_bank.sv
// Vector register bank: single/group/full-load/clear writes, two registered read ports.
// Always ready outside reset; a FULL load spans NREGS/LANES accepted beats.
module vreg_bank
  import vreg_pkg::*;
#(
  parameter int NREGS = 16,
  parameter int RW    = 32,
  parameter int LANES = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic [1:0]                cmd_mode,
  input  logic [$clog2(NREGS)-1:0]  cmd_addr,
  input  logic [LANES*RW-1:0]       wdata,
  input  logic [$clog2(NREGS)-1:0]  rd_addr0,
  input  logic [$clog2(NREGS)-1:0]  rd_addr1,
  output logic [RW-1:0]             rd_data0,
  output logic [RW-1:0]             rd_data1,
  output logic                      busy,
  output logic                      done,
  output logic [NREGS*RW-1:0]       snapshot
);

  localparam int AW     = $clog2(NREGS);
  localparam int NBEATS = NREGS / LANES;
  localparam int CW     = beat_ctr_width(NREGS, LANES);
  localparam int LSH    = $clog2(LANES);

  logic [RW-1:0]    regs [NREGS];
  state_e           state;
  mode_e            mode;
  logic             xfer;
  logic [CW-1:0]    cnt;
  logic             tc;
  logic             ctr_en;
  logic             ctr_clr;
  logic [AW-1:0]    base;
  logic [LANES-1:0] lane_en;
  logic             clr_all;

  // Ready in both IDLE and LOAD; only held off while reset is asserted.
  assign cmd_ready = ~reset;
  assign mode      = mode_e'(cmd_mode);
  assign xfer      = cmd_valid & cmd_ready;

  assign ctr_en  = xfer && ((state == LOAD) || (mode == FULL));
  assign ctr_clr = (state == IDLE) && !ctr_en;

  vreg_beat_ctr #(
    .NBEATS (NBEATS),
    .CW     (CW)
  ) u_beat_ctr (
    .clk   (clk),
    .reset (reset),
    .en    (ctr_en),
    .clr   (ctr_clr),
    .cnt   (cnt),
    .tc    (tc)
  );

  always_comb begin
    base    = '0;
    lane_en = '0;
    clr_all = 1'b0;
    if (xfer) begin
      if (state == LOAD) begin
        base    = AW'(cnt) << LSH;
        lane_en = '1;
      end else begin
        case (mode)
          SINGLE: begin
            base    = cmd_addr;
            lane_en = LANES'(1);
          end
          GROUP: begin
            base    = cmd_addr;
            lane_en = '1;
          end
          FULL: begin
            base    = '0;
            lane_en = '1;
          end
          default: clr_all = 1'b1;
        endcase
      end
    end
  end

  // Lane k lands at base+k; AW-bit arithmetic gives the modulo-NREGS wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (clr_all) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        if (lane_en[k]) regs[base + AW'(k)] <= wdata[k*RW +: RW];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else begin
      rd_data0 <= regs[rd_addr0];
      rd_data1 <= regs[rd_addr1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (xfer) begin
        case (state)
          IDLE: begin
            if (mode != FULL || tc) begin
              done <= 1'b1;
            end else begin
              state <= LOAD;
              busy  <= 1'b1;
            end
          end
          default: begin
            if (tc) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_snap
    assign snapshot[i*RW +: RW] = regs[i];
  end

endmodule

// File: tb/tb_vreg_bank.sv
// Scoreboard bench for vreg_bank: reference model predicts reads, done, busy and snapshot per cycle.
module tb_vreg_bank;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int L  = 4;
  localparam int NB = N / L;
  localparam int SW = N * W;

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_GROUP  = 2'b01;
  localparam logic [1:0] M_FULL   = 2'b10;
  localparam logic [1:0] M_CLEAR  = 2'b11;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [1:0]     cmd_mode = 2'b00;
  logic [3:0]     cmd_addr = '0;
  logic [L*W-1:0] wdata = '0;
  logic [3:0]     rd_addr0 = '0;
  logic [3:0]     rd_addr1 = '0;
  logic [W-1:0]   rd_data0;
  logic [W-1:0]   rd_data1;
  logic           busy;
  logic           done;
  logic [SW-1:0]  snapshot;

  vreg_bank #(.NREGS(N), .RW(W), .LANES(L)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_mode  (cmd_mode),
    .cmd_addr  (cmd_addr),
    .wdata     (wdata),
    .rd_addr0  (rd_addr0),
    .rd_addr1  (rd_addr1),
    .rd_data0  (rd_data0),
    .rd_data1  (rd_data1),
    .busy      (busy),
    .done      (done),
    .snapshot  (snapshot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] rd0;
    logic [W-1:0] rd1;
    logic         dn;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] m [N];
  bit           m_load;
  int           m_beat;
  int           total = 0;
  int           bad = 0;
  int           busy_cnt;
  int           done_cnt;

  task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [SW-1:0] model_snap();
    logic [SW-1:0] s;
    for (int i = 0; i < N; i++) s[i*W +: W] = m[i];
    return s;
  endfunction

  function automatic logic [L*W-1:0] pk(input logic [W-1:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_xfer(input logic [1:0] md, input logic [3:0] ad,
                            input logic [L*W-1:0] wd, output logic dn);
    dn = 1'b0;
    if (m_load) begin
      for (int k = 0; k < L; k++) m[m_beat*L + k] = wd[k*W +: W];
      if (m_beat == NB - 1) begin
        m_load = 0;
        m_beat = 0;
        dn = 1'b1;
      end else begin
        m_beat++;
      end
    end else begin
      case (md)
        M_SINGLE: m[ad] = wd[W-1:0];
        M_GROUP:  for (int k = 0; k < L; k++) m[(int'(ad) + k) % N] = wd[k*W +: W];
        M_CLEAR:  for (int i = 0; i < N; i++) m[i] = '0;
        default: begin
          for (int k = 0; k < L; k++) m[k] = wd[k*W +: W];
          m_load = 1;
          m_beat = 1;
        end
      endcase
      dn = (md != M_FULL);
    end
  endtask

  // Drive one cycle at posedge+1, predict, then compare at the next posedge+1.
  task automatic cycle(input logic v, input logic [1:0] md, input logic [3:0] ad,
                       input logic [L*W-1:0] wd, input logic [3:0] a0, input logic [3:0] a1);
    exp_t e;
    logic dn;
    cmd_valid = v;
    cmd_mode  = md;
    cmd_addr  = ad;
    wdata     = wd;
    rd_addr0  = a0;
    rd_addr1  = a1;
    chk("ready", {511'b0, cmd_ready}, 1);
    e.rd0 = m[a0];
    e.rd1 = m[a1];
    dn = 1'b0;
    if (v) model_xfer(md, ad, wd, dn);
    e.dn = dn;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk("rd_data0", rd_data0, e.rd0);
    chk("rd_data1", rd_data1, e.rd1);
    chk("done", done, e.dn);
    chk("busy", busy, m_load);
    chk("snapshot", snapshot, model_snap());
    busy_cnt += busy;
    done_cnt += done;
    cmd_valid = 1'b0;
  endtask

  task automatic idle(input logic [3:0] a0, input logic [3:0] a1);
    cycle(1'b0, M_SINGLE, 4'd0, '0, a0, a1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    #2;
    chk("rst_rd0", rd_data0, 0);
    chk("rst_rd1", rd_data1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_snap", snapshot, 0);
    for (int i = 0; i < N; i++) m[i] = '0;
    m_load = 0;
    m_beat = 0;
    sbq.delete();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [SW-1:0] fexp;
    do_reset();

    // SINGLE addr 5; reading reg5 in the write cycle returns the old value
    cycle(1'b1, M_SINGLE, 4'd5, pk(32'hDEADBEEF, 32'h1, 32'h2, 32'h3), 4'd5, 4'd6);
    chk("single_reg5", snapshot[5*W +: W], 32'hDEADBEEF);
    chk("single_others", snapshot & ~({{(SW-W){1'b0}}, {W{1'b1}}} << (5*W)), 0);
    idle(4'd5, 4'd0);
    chk("single_rd", rd_data0, 32'hDEADBEEF);

    // GROUP wrapping past reg15
    cycle(1'b1, M_CLEAR, 4'd0, '0, 4'd5, 4'd5);
    cycle(1'b1, M_GROUP, 4'd14, pk(32'h11, 32'h22, 32'h33, 32'h44), 4'd14, 4'd0);
    chk("grp_r14", snapshot[14*W +: W], 32'h11);
    chk("grp_r15", snapshot[15*W +: W], 32'h22);
    chk("grp_r0", snapshot[0 +: W], 32'h33);
    chk("grp_r1", snapshot[1*W +: W], 32'h44);
    idle(4'd15, 4'd1);

    // FULL load with a 2-cycle gap after beat 1
    busy_cnt = 0;
    done_cnt = 0;
    cycle(1'b1, M_FULL, 4'd9, pk(1, 2, 3, 4), 4'd0, 4'd3);
    cycle(1'b1, M_CLEAR, 4'd7, pk(5, 6, 7, 8), 4'd1, 4'd4);
    idle(4'd4, 4'd7);
    idle(4'd5, 4'd8);
    cycle(1'b1, M_SINGLE, 4'd2, pk(9, 10, 11, 12), 4'd8, 4'd9);
    cycle(1'b1, M_GROUP, 4'd3, pk(13, 14, 15, 16), 4'd12, 4'd15);
    for (int i = 0; i < N; i++) fexp[i*W +: W] = W'(i + 1);
    chk("full_snap", snapshot, fexp);
    chk("full_busy_cycles", busy_cnt, 5);
    chk("full_done_pulses", done_cnt, 1);
    idle(4'd15, 4'd0);

    // CLEAR after the full load
    cycle(1'b1, M_CLEAR, 4'd0, '1, 4'd3, 4'd10);
    chk("clear_snap", snapshot, 0);
    chk("clear_done", done, 1);
    idle(4'd3, 4'd10);

    // Same-edge read/write of reg3
    cycle(1'b1, M_SINGLE, 4'd3, pk(32'hA5, 0, 0, 0), 4'd3, 4'd3);
    chk("rw_old", rd_data0, 0);
    idle(4'd3, 4'd2);
    chk("rw_new", rd_data0, 32'hA5);

    // Reset mid-FULL after beat 2; load must not resume
    cycle(1'b1, M_FULL, 4'd0, pk(21, 22, 23, 24), 4'd0, 4'd1);
    cycle(1'b1, M_FULL, 4'd0, pk(25, 26, 27, 28), 4'd4, 4'd5);
    cycle(1'b1, M_FULL, 4'd0, pk(29, 30, 31, 32), 4'd8, 4'd9);
    chk("mid_busy", busy, 1);
    do_reset();
    chk("post_rst_busy", busy, 0);
    cycle(1'b1, M_SINGLE, 4'd0, pk(7, 99, 99, 99), 4'd0, 4'd12);
    chk("post_rst_reg0", snapshot[0 +: W], 7);
    chk("post_rst_busy2", busy, 0);
    idle(4'd0, 4'd1);
    chk("post_rst_rd", rd_data0, 7);

    // Random mix of modes, gaps and read addresses
    for (int t = 0; t < 80; t++) begin
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 4'($urandom),
            {$urandom, $urandom, $urandom, $urandom}, 4'($urandom), 4'($urandom));
    end
    for (int t = 0; t < NB + 1; t++) cycle(1'b1, M_SINGLE, 4'd1, pk(32'h55, 0, 0, 0), 4'($urandom), 4'd1);
    chk("end_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vreg_bank.md
VREG_BANK -- requirements
Module: vreg_bank

Interface
REQ-001 The module SHALL have parameter NREGS, default 16, giving the number of vector registers (power of two, at least 2).
REQ-002 The module SHALL have parameter RW, default 32, giving the register width in bits.
REQ-003 The module SHALL have parameter LANES, default 4, giving registers per data beat (power of two, at most NREGS).
REQ-004 The module SHALL have port clk, input, 1 bit: clock, rising-edge.
REQ-005 The module SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port cmd_valid, input, 1 bit: command/beat valid.
REQ-007 The module SHALL have port cmd_ready, output, 1 bit: command/beat accepted when high together with cmd_valid.
REQ-008 The module SHALL have port cmd_mode, input, 2 bits: 00 SINGLE, 01 GROUP, 10 FULL, 11 CLEAR.
REQ-009 The module SHALL have port cmd_addr, input, log2(NREGS) bits: base register index.
REQ-010 The module SHALL have port wdata, input, LANES*RW bits: lane k = wdata[k*RW +: RW].
REQ-011 The module SHALL have ports rd_addr0 and rd_addr1, input, log2(NREGS) bits each: read addresses.
REQ-012 The module SHALL have ports rd_data0 and rd_data1, output, RW bits each: registered read data.
REQ-013 The module SHALL have port busy, output, 1 bit: high while a FULL load is in progress.
REQ-014 The module SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-015 The module SHALL have port snapshot, output, NREGS*RW bits: monitor view, with register i at [i*RW +: RW].

Function
REQ-016 A transfer SHALL occur on any rising clk edge where cmd_valid and cmd_ready are both high; there SHALL be no other writes.
REQ-017 In state IDLE, cmd_ready SHALL be 1.
REQ-018 A SINGLE transfer SHALL write reg[cmd_addr] with lane 0; other lanes SHALL be ignored.
REQ-019 A GROUP transfer SHALL write reg[(cmd_addr+k) mod NREGS] with lane k for k = 0..LANES-1, wrapping past NREGS-1 to 0.
REQ-020 A CLEAR transfer SHALL zero every register in the same edge.
REQ-021 A FULL transfer in IDLE SHALL write regs 0..LANES-1 with lanes 0..LANES-1 (beat 0), ignore cmd_addr, and move the FSM to LOAD with the beat counter at 1.
REQ-022 In LOAD, cmd_ready SHALL stay 1, and each transfer SHALL be beat b, writing reg[b*LANES+k] with lane k; cmd_mode and cmd_addr SHALL be ignored.
REQ-023 A cmd_valid low cycle in LOAD SHALL stall the load with no write and the counter held.
REQ-024 After beat NREGS/LANES-1, the FSM SHALL return to IDLE and the counter SHALL clear.
REQ-025 If NREGS equals LANES, FULL SHALL complete in the accept cycle and not enter LOAD.
REQ-026 busy SHALL be 1 exactly while the FSM is in LOAD.
REQ-027 done SHALL pulse high for one cycle, on the cycle after the accepting edge, for SINGLE, GROUP and CLEAR transfers, and for the final FULL beat.
REQ-028 rd_dataN SHALL equal reg[rd_addrN] as sampled at the previous edge, giving one-cycle latency.
REQ-029 A read during a write to the same register SHALL return the old value.
REQ-030 snapshot SHALL reflect register contents combinationally, so it updates right after each write edge.
REQ-031 Beat counter width SHALL be max(1, log2(NREGS/LANES)); all index arithmetic SHALL be modulo NREGS.

Reset
REQ-032 On reset assertion, at any time including mid-LOAD, all registers SHALL go to 0.
REQ-033 On reset assertion, the FSM SHALL go to IDLE and the beat counter SHALL go to 0.
REQ-034 On reset assertion, the outputs SHALL be: rd_data0 = 0, rd_data1 = 0, busy = 0, done = 0, snapshot = 0.
REQ-035 cmd_ready SHALL be 1 from the first edge after reset release.
REQ-036 A partially loaded FULL SHALL be discarded on reset and SHALL NOT resume.

Structure
REQ-037 Package vreg_pkg SHALL hold the cmd_mode encoding enum (SINGLE, GROUP, FULL, CLEAR) and the FSM state type (IDLE, LOAD).
REQ-038 One sub-module, vreg_beat_ctr, SHALL contain the beat counter with enable, clear and terminal-count flag; the register array and read ports SHALL stay in vreg_bank.

Verification
REQ-039 Scenario: SINGLE, addr 5, lane 0 = 0xDEADBEEF -> reg5 = 0xDEADBEEF, all other registers 0, done pulses 1 cycle later.
REQ-040 Scenario: GROUP, addr 14, lanes 0x11/0x22/0x33/0x44 -> reg14 = 0x11, reg15 = 0x22, reg0 = 0x33, reg1 = 0x44.
REQ-041 Scenario: FULL, 4 beats with register i = i+1 and a 2-cycle cmd_valid gap after beat 1 -> busy high for 5 cycles, snapshot shows 1..16, a single done pulse.
REQ-042 Scenario: reset asserted after beat 2 of a FULL -> all outputs 0, IDLE; a following SINGLE addr 0 value 7 -> reg0 = 7.
REQ-043 Scenario: rd_addr0 = 3 while the same edge writes reg3 = 0xA5 -> rd_data0 returns old 0, then 0xA5 one cycle later.
REQ-044 Scenario: CLEAR after full load -> snapshot = 0 on the next cycle, done pulses.
